// File: rtl/fab_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the fabric reset sequencer.
package fab_reset_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_ASSERT_FAB = 3'd1,
    ST_WAIT_MSS   = 3'd2,
    ST_REL_PERIPH = 3'd3,
    ST_REL_APP    = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd7
  } seq_state_e;

  // Minimum dwell in WAIT_MSS so the MSS handshake seen is one re-synchronized
  // after CORE_RESET_N was released, not a stale pre-release sample.
  localparam int unsigned MSS_SETTLE_CYCLES = 2;

  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fab_reset_sequencer_if.sv
// Board-side signals of the fabric reset sequencer.
interface fab_reset_sequencer_if;

  logic       FAB_CCC_LOCK;
  logic       MSS_READY;
  logic       INIT_DONE;
  logic       SW_RESET_REQ_N;
  logic       CORE_RESET_N;
  logic       PERIPH_RESET_N;
  logic       APP_RESET_N;
  logic       SEQ_DONE;
  logic       SEQ_FAULT;
  logic [2:0] SEQ_STATE;

  modport master (
    output FAB_CCC_LOCK, MSS_READY, INIT_DONE, SW_RESET_REQ_N,
    input  CORE_RESET_N, PERIPH_RESET_N, APP_RESET_N, SEQ_DONE, SEQ_FAULT, SEQ_STATE
  );

  modport slave (
    input  FAB_CCC_LOCK, MSS_READY, INIT_DONE, SW_RESET_REQ_N,
    output CORE_RESET_N, PERIPH_RESET_N, APP_RESET_N, SEQ_DONE, SEQ_FAULT, SEQ_STATE
  );

endinterface

// File: rtl/fab_reset_sequencer_sync.sv
// Two-flop synchronizer with a selectable reset value.
module fab_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fab_reset_sequencer.sv
// Fabric reset bring-up: lock filter, core reset pulse, MSS handshake,
// staggered peripheral/application release, fault latch on timeout.
module fab_reset_sequencer
  import fab_reset_pkg::*;
#(
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned HOLD_CYCLES    = 32,
  parameter int unsigned STAGE_GAP      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                 CLK_BASE,
  input  logic                 RESET_N,
  fab_reset_sequencer_if.slave bus
);

  localparam int unsigned TMR_W = timer_width(TIMEOUT_CYCLES, HOLD_CYCLES,
                                              STAGE_GAP, LOCK_FILTER);
  localparam int unsigned FLT_W = $clog2(LOCK_FILTER + 1);

  localparam logic [TMR_W-1:0] TMR_MAX      = '1;
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(STAGE_GAP - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(MSS_SETTLE_CYCLES - 1);
  localparam logic [FLT_W-1:0] FILT_LAST    = FLT_W'(LOCK_FILTER - 1);

  logic lock_s, mss_ready_s, init_done_s, sw_req_n_s;

  fab_sync_2ff #(.RESET_VAL(1'b0)) u_sync_lock (
    .clk(CLK_BASE), .rst_n(RESET_N), .d(bus.FAB_CCC_LOCK), .q(lock_s)
  );
  fab_sync_2ff #(.RESET_VAL(1'b0)) u_sync_mss (
    .clk(CLK_BASE), .rst_n(RESET_N), .d(bus.MSS_READY), .q(mss_ready_s)
  );
  fab_sync_2ff #(.RESET_VAL(1'b0)) u_sync_init (
    .clk(CLK_BASE), .rst_n(RESET_N), .d(bus.INIT_DONE), .q(init_done_s)
  );
  fab_sync_2ff #(.RESET_VAL(1'b1)) u_sync_sw (
    .clk(CLK_BASE), .rst_n(RESET_N), .d(bus.SW_RESET_REQ_N), .q(sw_req_n_s)
  );

  seq_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [FLT_W-1:0] filt_q, filt_d;
  logic             core_q, core_d;
  logic             periph_q, periph_d;
  logic             app_q, app_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             tmr_clr;
  logic             lock_loss;

  assign lock_loss = !lock_s &&
                     (state_q inside {ST_ASSERT_FAB, ST_WAIT_MSS, ST_REL_PERIPH,
                                      ST_REL_APP, ST_RUN});

  always_comb begin
    state_d = state_q;
    filt_d  = '0;
    tmr_clr = 1'b0;
    if (lock_loss) begin
      state_d = ST_WAIT_LOCK;
    end else if (!sw_req_n_s && state_q != ST_WAIT_LOCK) begin
      state_d = ST_WAIT_LOCK;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          // A held software request restarts the wait from scratch.
          if (!sw_req_n_s) begin
            tmr_clr = 1'b1;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d = ST_FAULT;
          end else if (lock_s) begin
            if (filt_q == FILT_LAST) state_d = ST_ASSERT_FAB;
            else                     filt_d  = filt_q + 1'b1;
          end
        end
        ST_ASSERT_FAB: begin
          if (timer_q == HOLD_LAST) state_d = ST_WAIT_MSS;
        end
        ST_WAIT_MSS: begin
          if (timer_q == TIMEOUT_LAST) begin
            state_d = ST_FAULT;
          end else if (timer_q >= SETTLE_LAST && mss_ready_s && init_done_s) begin
            state_d = ST_REL_PERIPH;
          end
        end
        ST_REL_PERIPH: begin
          if (timer_q == GAP_LAST) state_d = ST_REL_APP;
        end
        ST_REL_APP: begin
          if (timer_q == GAP_LAST) state_d = ST_RUN;
        end
        ST_RUN:   state_d = ST_RUN;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_WAIT_LOCK;
      endcase
    end

    if (state_d != state_q || tmr_clr) timer_d = '0;
    else if (timer_q != TMR_MAX)       timer_d = timer_q + 1'b1;
    else                               timer_d = timer_q;
  end

  // Outputs decode the state being entered so they register on the same edge.
  always_comb begin
    core_d   = 1'b0;
    periph_d = 1'b0;
    app_d    = 1'b0;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    case (state_d)
      ST_WAIT_MSS, ST_REL_PERIPH: core_d = 1'b1;
      ST_REL_APP: begin
        core_d   = 1'b1;
        periph_d = 1'b1;
      end
      ST_RUN: begin
        core_d   = 1'b1;
        periph_d = 1'b1;
        app_d    = 1'b1;
        done_d   = 1'b1;
      end
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_BASE or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_WAIT_LOCK;
      timer_q  <= '0;
      filt_q   <= '0;
      core_q   <= 1'b0;
      periph_q <= 1'b0;
      app_q    <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      filt_q   <= filt_d;
      core_q   <= core_d;
      periph_q <= periph_d;
      app_q    <= app_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.CORE_RESET_N   = core_q;
  assign bus.PERIPH_RESET_N = periph_q;
  assign bus.APP_RESET_N    = app_q;
  assign bus.SEQ_DONE       = done_q;
  assign bus.SEQ_FAULT      = fault_q;
  assign bus.SEQ_STATE      = state_q;

endmodule

// File: tb/tb_fab_reset_sequencer.sv
// Scoreboard bench for fab_reset_sequencer with a cycle-level reference model.
module tb_fab_reset_sequencer;

  localparam int unsigned LF = 4;
  localparam int unsigned HC = 8;
  localparam int unsigned SG = 3;
  localparam int unsigned TO = 100;

  logic clk;
  logic rst_n;

  fab_reset_sequencer_if ifc ();

  fab_reset_sequencer #(
    .LOCK_FILTER(LF), .HOLD_CYCLES(HC), .STAGE_GAP(SG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_BASE(clk),
    .RESET_N (rst_n),
    .bus     (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {core, periph, app, done, fault, state[2:0]}
  logic [7:0] dut_vec;
  assign dut_vec = {ifc.CORE_RESET_N, ifc.PERIPH_RESET_N, ifc.APP_RESET_N,
                    ifc.SEQ_DONE, ifc.SEQ_FAULT, ifc.SEQ_STATE};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  vec;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  logic [7:0]  exp_now;
  logic [7:0]  exp_base;
  logic [7:0]  dut_last;

  // Reference model: phase number as published on SEQ_STATE, cycles spent in
  // the phase, and the run of consecutive synchronized lock-high samples.
  int ph, dwell, streak;
  bit ml1, ml2, mm1, mm2, mi1, mi2, mw1, mw2;
  bit in_rst;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] vec_of(input int p);
    logic [2:0] s;
    s = p[2:0];
    return {(p >= 2 && p <= 5), (p == 4 || p == 5), (p == 5), (p == 5), (p == 7), s};
  endfunction

  task automatic model_reset();
    ph = 0; dwell = 0; streak = 0;
    ml1 = 0; ml2 = 0; mm1 = 0; mm2 = 0; mi1 = 0; mi2 = 0; mw1 = 1; mw2 = 1;
  endtask

  task automatic model_step();
    bit l, m, i, w, restart;
    int nxt;
    l = ml2; m = mm2; i = mi2; w = mw2;
    ml2 = ml1; ml1 = ifc.FAB_CCC_LOCK;
    mm2 = mm1; mm1 = ifc.MSS_READY;
    mi2 = mi1; mi1 = ifc.INIT_DONE;
    mw2 = mw1; mw1 = ifc.SW_RESET_REQ_N;
    nxt = ph;
    restart = 0;
    if (ph >= 1 && ph <= 5 && !l) nxt = 0;
    else if (ph != 0 && !w) nxt = 0;
    else if (ph == 0) begin
      if (!w) begin
        restart = 1;
        streak  = 0;
      end else if (dwell + 1 == TO) nxt = 7;
      else begin
        streak = l ? streak + 1 : 0;
        if (streak == LF) nxt = 1;
      end
    end else if (ph == 1) begin
      if (dwell + 1 == HC) nxt = 2;
    end else if (ph == 2) begin
      if (dwell + 1 == TO) nxt = 7;
      else if (dwell + 1 >= 2 && m && i) nxt = 3;
    end else if (ph == 3 || ph == 4) begin
      if (dwell + 1 == SG) nxt = ph + 1;
    end
    if (nxt != 0) streak = 0;
    dwell = (nxt != ph || restart) ? 0 : dwell + 1;
    ph = nxt;
  endtask

  // Model: advances on each clock edge and snaps to reset on RESET_N assertion.
  initial begin
    in_rst   = 1;
    cyc      = 0;
    exp_now  = '0;
    exp_base = '0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n && !in_rst) begin
        in_rst = 1;
        model_reset();
        if (sb_q.size() > 0 && sb_q[$].cyc == cyc) void'(sb_q.pop_back());
        exp_now = '0;
        if (exp_now != exp_base) sb_q.push_back('{cyc: cyc, vec: exp_now});
      end else begin
        cyc++;
        exp_base = exp_now;
        if (!rst_n) model_reset();
        else begin
          in_rst = 0;
          model_step();
        end
        exp_now = vec_of(ph);
        if (exp_now != exp_base) sb_q.push_back('{cyc: cyc, vec: exp_now});
      end
    end
  end

  // Monitor: every visible output change must match the next queued prediction.
  initial begin
    exp_t e;
    dut_last = '0;
    forever begin
      @(negedge clk);
      if (dut_vec !== dut_last) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: outputs became %0h, expected no change from %0h (cycle %0d)",
                   dut_vec, dut_last, cyc);
        end else begin
          e = sb_q.pop_front();
          check("sb_vec", dut_vec, e.vec);
          check("sb_cycle", cyc, e.cyc);
        end
        dut_last = dut_vec;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lock, input logic mss, input logic init, input logic sw);
    ifc.FAB_CCC_LOCK   = lock;
    ifc.MSS_READY      = mss;
    ifc.INIT_DONE      = init;
    ifc.SW_RESET_REQ_N = sw;
  endtask

  task automatic wait_bit(input int unsigned idx, input logic val,
                          input int unsigned limit, input string name);
    int unsigned n;
    n = 0;
    while (dut_vec[idx] !== val && n < limit) begin
      step(1);
      n++;
    end
    if (dut_vec[idx] !== val) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: output bit %0d is %b after %0d cycles, required %b",
               name, idx, dut_vec[idx], n, val);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step(3);
    check("reset_vec", dut_vec, 8'h00);
    rst_n = 1'b1;

    // Clean bring-up: lock at cycle ~10, MSS handshake 5 cycles after core release.
    step(7);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    wait_bit(7, 1'b1, 60, "bringup_core_rise");
    check("bringup_wait_mss", dut_vec, 8'h82);
    step(5);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    step(5);
    check("bringup_rel_periph", dut_vec, 8'h83);
    step(1);
    check("bringup_periph_up", dut_vec, 8'hC4);
    step(3);
    check("bringup_run", dut_vec, 8'hF5);

    // Lock glitch: 3 high, 1 low, then high; filter restarts.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step(8);
    check("glitch_pre", dut_vec, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step(3);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step(5);
    check("glitch_still_waiting", dut_vec, 8'h00);
    step(1);
    check("glitch_assert_fab", dut_vec, 8'h01);

    // MSS timeout: handshake never arrives.
    wait_bit(7, 1'b1, 30, "timeout_core_rise");
    step(99);
    check("timeout_last_wait", dut_vec, 8'h82);
    step(1);
    check("timeout_fault", dut_vec, 8'h0F);
    step(4);
    check("timeout_fault_held", dut_vec, 8'h0F);

    // Software restart out of FAULT.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    check("sw_fault_before", dut_vec, 8'h0F);
    step(1);
    check("sw_wait_lock", dut_vec, 8'h00);
    step(2);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    wait_bit(7, 1'b1, 60, "sw_core_rise");
    step($urandom_range(1, 10));
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    wait_bit(4, 1'b1, 40, "sw_done");
    check("sw_run", dut_vec, 8'hF5);

    // One-cycle lock loss in RUN.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    step(1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    step(1);
    check("lockloss_before", dut_vec, 8'hF5);
    step(1);
    check("lockloss_drop", dut_vec, 8'h00);
    wait_bit(4, 1'b1, 80, "lockloss_redone");
    check("lockloss_run", dut_vec, 8'hF5);

    // RESET_N asserted while in REL_APP.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step(5);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    wait_bit(6, 1'b1, 80, "rst_periph_rise");
    check("rst_in_rel_app", dut_vec, 8'hC4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_vec", dut_vec, 8'h00);
    step(2);
    rst_n = 1'b1;
    wait_bit(4, 1'b1, 80, "rst_redone");
    check("rst_run", dut_vec, 8'hF5);

    // Randomized segments, checked by the scoreboard.
    for (int s = 0; s < 40; s++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      step($urandom_range(1, 40));
      check("rand_model", dut_vec, exp_now);
    end

    drive(1'b1, 1'b1, 1'b1, 1'b1);
    step(60);
    check("final_model", dut_vec, exp_now);
    step(2);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
